vend_controller: RTL and testbench
==================================

Name: vend_controller

Overview:
Multi-product vending controller that sequences the coin-accept, product-select, dispense and change-return flow around the vending datapath.
- Accumulates 5rs/10rs coins into a credit register and checks each selection against its price and per-product stock.
- Drives a dispense motor through a req/ack handshake.
- Returns change or refund one coin per cycle.
- Sits between the coin acceptor / keypad front end and the dispense mechanism.

Parameters:
- PRICE0, 3, price of product 0 in 5rs units (15rs)
- PRICE1, 4, price of product 1 in 5rs units
- PRICE2, 5, price of product 2 in 5rs units
- PRICE3, 6, price of product 3 in 5rs units
- MAX_CREDIT, 20, maximum credit in 5rs units; must be < 2^CREDIT_W
- CREDIT_W, 5, credit register width
- STOCK_INIT, 7, stock loaded per product at reset and restock (3-bit)
- TIMEOUT, 255, idle cycles in CREDIT before auto-refund (8-bit counter)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- coin  in  2  00 none, 01 5rs, 10 10rs, 11 invalid; sampled every cycle
- sel_valid  in  1  selection strobe, one cycle
- sel  in  2  product index
- cancel  in  1  refund request, one cycle
- restock  in  1  reload all stock counters
- dispense_ack  in  1  motor done
- dispense_req  out  1  dispense request
- dispense_sel  out  2  product being dispensed
- change_5  out  1  one-cycle pulse = eject one 5rs coin
- change_10  out  1  one-cycle pulse = eject one 10rs coin
- credit  out  CREDIT_W  current credit, in 5rs units
- coin_reject  out  1  one-cycle pulse, coin returned unaccepted
- sel_reject  out  1  one-cycle pulse, selection refused
- sold_out  out  4  bit i high when stock[i]==0
- busy  out  1  high in DISPENSE or CHANGE

Behaviour:
- Reset (async, immediate, no clock edge needed):
  - state=IDLE, credit=0, all pulses and dispense_req = 0, dispense_sel=0.
  - Every stock counter = STOCK_INIT; timeout counter = 0.
- All other outputs are registered; pulses last exactly one cycle.
- Coin acceptance:
  - Accepted only in IDLE or CREDIT, and only when credit + value <= MAX_CREDIT.
  - On acceptance, credit updates the next cycle and state moves to CREDIT.
  - coin=11, a coin arriving in DISPENSE/CHANGE, or an overflowing coin -> coin_reject pulse next cycle; credit unchanged.
- IDLE:
  - sel_valid -> sel_reject.
  - cancel ignored.
  - restock reloads all counters to STOCK_INIT.
  - restock is ignored in every other state.
- CREDIT, priority cancel > timeout > sel_valid:
  - cancel -> CHANGE; a coin arriving in the same cycle is rejected.
  - Timeout counter increments each cycle with no coin/sel/cancel and clears on any of them. At TIMEOUT -> CHANGE.
  - sel_valid checks, using credit before any same-cycle coin:
    - stock[sel]==0 or credit < PRICE[sel] -> sel_reject, stay in CREDIT.
    - Otherwise -> DISPENSE with dispense_sel=sel latched.
  - A coin in the same cycle as an accepted selection is rejected.
  - A coin in the same cycle as a refused selection is accepted.
- DISPENSE:
  - dispense_req held high and dispense_sel held stable until dispense_ack is sampled high.
  - Next cycle: dispense_req=0, stock[sel] decrements by 1, credit -= PRICE[sel].
  - Then go to CHANGE if the new credit > 0, else IDLE.
  - No timeout while in DISPENSE.
- CHANGE, one coin per cycle:
  - If credit >= 2: change_10, credit -= 2.
  - Else if credit == 1: change_5, credit = 0.
  - When credit reaches 0 -> IDLE.
  - Number of pulses = floor(c/2) + (c mod 2).
- sold_out is combinational from the stock counters and updates the cycle after decrement or reload.
- Stock never underflows; a selection with stock 0 is always refused.

Test Plan:
1. Coin 10rs, 10rs (credit=4); sel=0; ack 3 cycles later -> dispense_req high 3 cycles with dispense_sel=0; then one change_5, credit=0, IDLE, stock0=6.
2. Credit=2, sel=2 (price 5) -> sel_reject pulse, credit stays 2, no dispense_req.
3. Credit=5, cancel -> change_10, change_10, change_5 on consecutive cycles; credit 3 -> 1 -> 0; back to IDLE.
4. STOCK_INIT=1: buy product 3 with credit 6 -> sold_out=1000; next sel=3 with credit 6 -> sel_reject; restock in IDLE -> sold_out=0000.
5. Credit=19, coin 10rs -> coin_reject, credit 19; coin=11 -> coin_reject; coin during DISPENSE -> coin_reject.
6. TIMEOUT=10, credit=1, no activity 10 cycles -> change_5, IDLE. Separately, assert rst mid-DISPENSE -> dispense_req, credit, busy = 0 before the next clk edge; stock = STOCK_INIT.

Source files
------------

// File: rtl/vend_controller.sv
// Vending controller: coin credit, product select, dispense handshake
// and one-coin-per-cycle change return around the vending datapath.
module vend_controller #(
  parameter int PRICE0     = 3,
  parameter int PRICE1     = 4,
  parameter int PRICE2     = 5,
  parameter int PRICE3     = 6,
  parameter int MAX_CREDIT = 20,
  parameter int CREDIT_W   = 5,
  parameter int STOCK_INIT = 7,
  parameter int TIMEOUT    = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          coin,
  input  logic                sel_valid,
  input  logic [1:0]          sel,
  input  logic                cancel,
  input  logic                restock,
  input  logic                dispense_ack,
  output logic                dispense_req,
  output logic [1:0]          dispense_sel,
  output logic                change_5,
  output logic                change_10,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_reject,
  output logic                sel_reject,
  output logic [3:0]          sold_out,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE, CREDIT, DISPENSE, CHANGE
  } state_t;

  localparam logic [CREDIT_W-1:0] P0 = CREDIT_W'(PRICE0);
  localparam logic [CREDIT_W-1:0] P1 = CREDIT_W'(PRICE1);
  localparam logic [CREDIT_W-1:0] P2 = CREDIT_W'(PRICE2);
  localparam logic [CREDIT_W-1:0] P3 = CREDIT_W'(PRICE3);
  localparam logic [CREDIT_W:0]   MAXC = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] ONE = CREDIT_W'(1);
  localparam logic [CREDIT_W-1:0] TWO = CREDIT_W'(2);
  localparam logic [2:0]          SINIT = 3'(STOCK_INIT);
  localparam logic [7:0]          TLAST = 8'(TIMEOUT - 1);

  function automatic logic [CREDIT_W-1:0] price(
    input logic [1:0] s
  );
    logic [CREDIT_W-1:0] p;
    p = P0;
    unique case (s)
      2'd0: p = P0;
      2'd1: p = P1;
      2'd2: p = P2;
      2'd3: p = P3;
    endcase
    return p;
  endfunction

  state_t              state, state_d;
  logic [CREDIT_W-1:0] credit_d;
  logic [3:0][2:0]     stock, stock_d;
  logic [7:0]          tmo, tmo_d;
  logic [1:0]          dsel_d;
  logic                req_d;
  logic                c5_d, c10_d;
  logic                crej_d, srej_d;

  logic [1:0]          coin_val;
  logic                coin_bad;
  logic                coin_any;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_fits;
  logic                take_coin;
  logic                activity;
  logic                sel_ok;
  logic [CREDIT_W-1:0] rem;

  // Decode the coin acceptor code into 5rs units.
  always_comb begin
    coin_val = 2'd0;
    coin_bad = 1'b0;
    unique case (1'b1)
      coin == 2'b01: coin_val = 2'd1;
      coin == 2'b10: coin_val = 2'd2;
      coin == 2'b11: coin_bad = 1'b1;
      coin == 2'b00: coin_val = 2'd0;
    endcase
  end

  assign coin_any  = coin != 2'b00;
  assign coin_sum  = {1'b0, credit}
                   + {{(CREDIT_W-1){1'b0}}, coin_val};
  assign coin_fits = !coin_bad && coin_sum <= MAXC;
  assign activity  = coin_any || sel_valid || cancel;
  assign sel_ok    = stock[sel] != 3'd0
                   && credit >= price(sel);
  assign rem       = credit - price(dispense_sel);

  assign busy = state == DISPENSE || state == CHANGE;

  for (genvar i = 0; i < 4; i++) begin : g_so
    assign sold_out[i] = stock[i] == 3'd0;
  end

  // Next-state, datapath updates and pulse generation.
  always_comb begin
    state_d   = state;
    credit_d  = credit;
    stock_d   = stock;
    tmo_d     = '0;
    dsel_d    = dispense_sel;
    req_d     = dispense_req;
    c5_d      = 1'b0;
    c10_d     = 1'b0;
    crej_d    = 1'b0;
    srej_d    = 1'b0;
    take_coin = 1'b0;
    unique case (state)
      IDLE: begin
        if (restock) stock_d = {4{SINIT}};
        if (sel_valid) srej_d = 1'b1;
        take_coin = 1'b1;
      end
      CREDIT: begin
        tmo_d = activity ? 8'd0 : tmo + 8'd1;
        if (cancel) begin
          state_d = CHANGE;
          tmo_d   = '0;
          crej_d  = coin_any;
        end else if (!activity && tmo == TLAST) begin
          state_d = CHANGE;
          tmo_d   = '0;
        end else if (sel_valid && sel_ok) begin
          state_d = DISPENSE;
          dsel_d  = sel;
          req_d   = 1'b1;
          tmo_d   = '0;
          crej_d  = coin_any;
        end else begin
          srej_d    = sel_valid;
          take_coin = 1'b1;
        end
      end
      DISPENSE: begin
        crej_d = coin_any;
        if (dispense_ack) begin
          req_d    = 1'b0;
          credit_d = rem;
          if (stock[dispense_sel] != 3'd0)
            stock_d[dispense_sel] =
              stock[dispense_sel] - 3'd1;
          state_d = (rem != '0) ? CHANGE : IDLE;
        end
      end
      CHANGE: begin
        crej_d = coin_any;
        if (credit >= TWO) begin
          c10_d    = 1'b1;
          credit_d = credit - TWO;
          state_d  = (credit == TWO) ? IDLE : CHANGE;
        end else if (credit == ONE) begin
          c5_d     = 1'b1;
          credit_d = '0;
          state_d  = IDLE;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
    if (take_coin && coin_any) begin
      if (coin_fits) begin
        credit_d = coin_sum[CREDIT_W-1:0];
        state_d  = CREDIT;
      end else begin
        crej_d = 1'b1;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      credit       <= '0;
      stock        <= {4{SINIT}};
      tmo          <= '0;
      dispense_sel <= '0;
      dispense_req <= 1'b0;
      change_5     <= 1'b0;
      change_10    <= 1'b0;
      coin_reject  <= 1'b0;
      sel_reject   <= 1'b0;
    end else begin
      state        <= state_d;
      credit       <= credit_d;
      stock        <= stock_d;
      tmo          <= tmo_d;
      dispense_sel <= dsel_d;
      dispense_req <= req_d;
      change_5     <= c5_d;
      change_10    <= c10_d;
      coin_reject  <= crej_d;
      sel_reject   <= srej_d;
    end
  end

endmodule

// File: tb/tb_vend_controller.sv
// Directed bench for vend_controller: vector table plus
// hand sequences for stock, overflow, timeout and reset.
module tb_vend_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] coin;
  logic       sel_valid;
  logic [1:0] sel;
  logic       cancel;
  logic       restock;
  logic       dispense_ack;
  logic       dispense_req;
  logic [1:0] dispense_sel;
  logic       change_5;
  logic       change_10;
  logic [4:0] credit;
  logic       coin_reject;
  logic       sel_reject;
  logic [3:0] sold_out;
  logic       busy;

  always #5 clk = ~clk;

  vend_controller #(.TIMEOUT(10)) dut (
    .clk(clk), .rst(rst), .coin(coin),
    .sel_valid(sel_valid), .sel(sel),
    .cancel(cancel), .restock(restock),
    .dispense_ack(dispense_ack),
    .dispense_req(dispense_req),
    .dispense_sel(dispense_sel),
    .change_5(change_5), .change_10(change_10),
    .credit(credit), .coin_reject(coin_reject),
    .sel_reject(sel_reject), .sold_out(sold_out),
    .busy(busy)
  );

  typedef struct {
    logic [1:0] coin;
    logic       sv;
    logic [1:0] sel;
    logic       cancel;
    logic       ack;
    logic [4:0] cr;
    logic       req;
    logic       c5;
    logic       c10;
    logic       crej;
    logic       srej;
    logic       busy;
  } vec_t;

  vec_t vt[$];
  int total = 0;
  int bad = 0;
  int n10, n5;

  function automatic vec_t mk(
    input logic [1:0] c, input logic v,
    input logic [1:0] s, input logic cn,
    input logic a, input logic [4:0] cr,
    input logic rq, input logic c5,
    input logic c10, input logic cj,
    input logic sj, input logic b
  );
    vec_t r;
    r.coin = c; r.sv = v; r.sel = s;
    r.cancel = cn; r.ack = a; r.cr = cr;
    r.req = rq; r.c5 = c5; r.c10 = c10;
    r.crej = cj; r.srej = sj; r.busy = b;
    return r;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  task automatic cyc(input logic [1:0] c,
                     input logic v,
                     input logic [1:0] s,
                     input logic cn,
                     input logic rs,
                     input logic a);
    coin = c; sel_valid = v; sel = s;
    cancel = cn; restock = rs; dispense_ack = a;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(2'b00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    n10 = 0;
    n5 = 0;
    for (int i = 0; i < 20; i++) begin
      if (!busy) break;
      idle();
      n10 += int'(change_10);
      n5 += int'(change_5);
    end
  endtask

  initial begin
    rst = 1'b1;
    coin = 2'b00; sel_valid = 1'b0; sel = 2'd0;
    cancel = 1'b0; restock = 1'b0;
    dispense_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", 32'({credit, dispense_req,
        dispense_sel, change_5, change_10,
        coin_reject, sel_reject, busy, sold_out}),
        32'd0);
    @(negedge clk);
    rst = 1'b0;

    // buy product 0 with 20rs, ack after 3 cycles
    vt.push_back(mk(2, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(2, 0, 0, 0, 0, 4, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 1, 0, 0, 0, 4, 1, 0, 0, 0, 0, 1));
    vt.push_back(mk(0, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 1));
    vt.push_back(mk(0, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 1));
    vt.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // insufficient credit for product 2
    vt.push_back(mk(2, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 1, 2, 0, 0, 2, 0, 0, 0, 0, 1, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0));
    // credit 5 then cancel: 10, 10, 5
    vt.push_back(mk(1, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(2, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 1, 0, 5, 0, 0, 0, 0, 0, 1));
    vt.push_back(mk(0, 0, 0, 0, 0, 3, 0, 0, 1, 0, 0, 1));
    vt.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    // IDLE: invalid coin, selection, cancel
    vt.push_back(mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    vt.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    vt.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    // coin alongside refused / accepted selection
    vt.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(2, 1, 0, 0, 0, 3, 0, 0, 0, 0, 1, 0));
    vt.push_back(mk(1, 1, 0, 0, 0, 3, 1, 0, 0, 1, 0, 1));
    vt.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    foreach (vt[i]) begin
      cyc(vt[i].coin, vt[i].sv, vt[i].sel,
          vt[i].cancel, 1'b0, vt[i].ack);
      chk($sformatf("vec%0d", i),
          32'({credit, dispense_req, dispense_sel,
               change_5, change_10, coin_reject,
               sel_reject, busy, sold_out}),
          32'({vt[i].cr, vt[i].req, 2'b00,
               vt[i].c5, vt[i].c10, vt[i].crej,
               vt[i].srej, vt[i].busy, 4'b0000}));
    end

    // credit overflow and coins while dispensing
    repeat (9) cyc(2'b10, 0, 2'd0, 0, 0, 0);
    cyc(2'b01, 0, 2'd0, 0, 0, 0);
    chk("credit19", 32'(credit), 32'd19);
    cyc(2'b10, 0, 2'd0, 0, 0, 0);
    chk("ovf_rej", 32'({coin_reject, credit}),
        32'({1'b1, 5'd19}));
    cyc(2'b11, 0, 2'd0, 0, 0, 0);
    chk("bad_rej", 32'({coin_reject, credit}),
        32'({1'b1, 5'd19}));
    cyc(2'b01, 0, 2'd0, 0, 0, 0);
    chk("credit_max", 32'({coin_reject, credit}),
        32'({1'b0, 5'd20}));
    cyc(2'b00, 1, 2'd3, 0, 0, 0);
    chk("disp3", 32'({dispense_req, dispense_sel}),
        32'({1'b1, 2'd3}));
    cyc(2'b01, 0, 2'd0, 0, 0, 0);
    chk("disp_coin", 32'({dispense_req, coin_reject,
        credit}), 32'({1'b1, 1'b1, 5'd20}));
    cyc(2'b00, 0, 2'd0, 0, 0, 1);
    chk("disp_ack", 32'({dispense_req, busy, credit}),
        32'({1'b0, 1'b1, 5'd14}));
    drain();
    chk("chg14", 32'({n10[7:0], n5[7:0], busy,
        credit}), 32'({8'd7, 8'd0, 1'b0, 5'd0}));

    // empty product 3 (6 left), refuse, restock
    repeat (6) begin
      repeat (3) cyc(2'b10, 0, 2'd0, 0, 0, 0);
      cyc(2'b00, 1, 2'd3, 0, 0, 0);
      cyc(2'b00, 0, 2'd0, 0, 0, 1);
    end
    chk("sold3", 32'({sold_out, busy}),
        32'({4'b1000, 1'b0}));
    repeat (3) cyc(2'b10, 0, 2'd0, 0, 0, 0);
    cyc(2'b00, 1, 2'd3, 0, 0, 0);
    chk("sold_rej", 32'({sel_reject, dispense_req,
        credit}), 32'({1'b1, 1'b0, 5'd6}));
    cyc(2'b00, 0, 2'd0, 0, 1, 0);
    chk("rs_ign", 32'(sold_out), 32'b1000);
    cyc(2'b00, 0, 2'd0, 1, 0, 0);
    drain();
    chk("chg6", 32'({n10[7:0], n5[7:0], credit}),
        32'({8'd3, 8'd0, 5'd0}));
    cyc(2'b00, 0, 2'd0, 0, 1, 0);
    chk("restock", 32'(sold_out), 32'd0);

    // idle timeout refund
    cyc(2'b01, 0, 2'd0, 0, 0, 0);
    repeat (9) idle();
    chk("tmo_pre", 32'({busy, credit}),
        32'({1'b0, 5'd1}));
    idle();
    chk("tmo_hit", 32'(busy), 32'd1);
    idle();
    chk("tmo_c5", 32'({change_5, credit, busy}),
        32'({1'b1, 5'd0, 1'b0}));

    // asynchronous reset in the middle of a dispense
    cyc(2'b10, 0, 2'd0, 0, 0, 0);
    cyc(2'b10, 0, 2'd0, 0, 0, 0);
    cyc(2'b00, 1, 2'd1, 0, 0, 0);
    chk("pre_rst", 32'({dispense_req, busy}),
        32'({1'b1, 1'b1}));
    sel_valid = 1'b0;
    rst = 1'b1;
    #2;
    chk("async_rst", 32'({dispense_req, credit, busy,
        sold_out}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle();
    chk("post_rst", 32'({dispense_req, credit, busy,
        sold_out, coin_reject, sel_reject}), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
